// File: rtl/double_buffer_swap_ctrl_if.sv
// Writer/reader handshake bundle for double_buffer_swap_ctrl.
// master: HDMI writer + matrix reader side; slave: the swap controller.
interface double_buffer_swap_ctrl_if #(
  parameter int ADDRESS_DEPTH = 512,
  parameter int BANK_COUNT    = 3
);
  localparam int AW = $clog2(ADDRESS_DEPTH);
  localparam int BW = ($clog2(BANK_COUNT) > 0) ? $clog2(BANK_COUNT) : 1;

  logic          wr_valid;
  logic [BW-1:0] wr_bank;
  logic          wr_frame_end;
  logic          wr_ready;
  logic [1:0]    wr_ce;
  logic [BW-1:0] wr_bank_q;
  logic [AW-1:0] wr_addr;
  logic          rd_frame_done;
  logic          rd_sel;
  logic          frame_valid;
  logic          swap_pulse;
  logic          overflow;

  modport master (
    output wr_valid, wr_bank, wr_frame_end, rd_frame_done,
    input  wr_ready, wr_ce, wr_bank_q, wr_addr, rd_sel, frame_valid,
           swap_pulse, overflow
  );

  modport slave (
    input  wr_valid, wr_bank, wr_frame_end, rd_frame_done,
    output wr_ready, wr_ce, wr_bank_q, wr_addr, rd_sel, frame_valid,
           swap_pulse, overflow
  );
endinterface

// File: rtl/double_buffer_swap_ctrl.sv
// Double-buffer swap controller: generates per-bank write addresses and
// buffer write enables for the buffer being filled, and swaps the buffers
// once the writer has ended a frame and the reader has finished its frame.
// Optional feature macro: DOUBLE_BUFFER_FRAME_DROP_EN -- while waiting for
// the reader, keep accepting (and discarding) words and count dropped frames
// on drop_count instead of stalling the writer.
module double_buffer_swap_ctrl #(
  parameter int ADDRESS_DEPTH = 512,
  parameter int BANK_COUNT    = 3,
  parameter int FRAME_WORDS   = 512
) (
  input  logic        clk,
  input  logic        reset,
`ifdef DOUBLE_BUFFER_FRAME_DROP_EN
  output logic [15:0] drop_count,
`endif
  double_buffer_swap_ctrl_if.slave bus
);
  localparam int AW = $clog2(ADDRESS_DEPTH);
  localparam int BW = ($clog2(BANK_COUNT) > 0) ? $clog2(BANK_COUNT) : 1;
  localparam logic [AW:0] FRAME_LIM = (AW+1)'(FRAME_WORDS);
  localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);
  localparam logic [BW:0] BANK_LIM  = (BW+1)'(BANK_COUNT);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILL    = 2'd1,
    ST_PENDING = 2'd2,
    ST_SWAP    = 2'd3
  } state_t;

  state_t        state_r, state_next_s;
  logic          wr_ready_r, ready_next_s;
  logic          wr_sel_r, rd_sel_r;
  logic          frame_valid_r, swap_pulse_r, overflow_r;
  logic [1:0]    wr_ce_r;
  logic [BW-1:0] wr_bank_q_r;
  logic [AW-1:0] wr_addr_r;
  logic [AW:0]   cnt_r [BANK_COUNT];
  logic [AW:0]   cur_cnt_s;
  logic          accept_s, bank_ok_s, drop_mode_s, write_s, ovf_hit_s;

  assign bus.wr_ready    = wr_ready_r;
  assign bus.wr_ce       = wr_ce_r;
  assign bus.wr_bank_q   = wr_bank_q_r;
  assign bus.wr_addr     = wr_addr_r;
  assign bus.rd_sel      = rd_sel_r;
  assign bus.frame_valid = frame_valid_r;
  assign bus.swap_pulse  = swap_pulse_r;
  assign bus.overflow    = overflow_r;

  // Next-state decode: the swap happens only once both sides have finished.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.wr_frame_end) state_next_s = ST_SWAP;
        else                  state_next_s = ST_IDLE;
      end
      ST_FILL: begin
        if (bus.wr_frame_end && bus.rd_frame_done) state_next_s = ST_SWAP;
        else if (bus.wr_frame_end)                 state_next_s = ST_PENDING;
        else                                       state_next_s = ST_FILL;
      end
      ST_PENDING: begin
        if (bus.rd_frame_done) state_next_s = ST_SWAP;
        else                   state_next_s = ST_PENDING;
      end
      ST_SWAP: state_next_s = ST_FILL;
      default: state_next_s = ST_IDLE;
    endcase
`ifdef DOUBLE_BUFFER_FRAME_DROP_EN
    ready_next_s = (state_next_s != ST_SWAP);
`else
    ready_next_s = (state_next_s == ST_IDLE) || (state_next_s == ST_FILL);
`endif
  end

  // State register; wr_ready is registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      wr_ready_r <= 1'b1;
    end else begin
      state_r    <= state_next_s;
      wr_ready_r <= ready_next_s;
    end
  end

  // Select the running word count of the addressed bank (0 if out of range).
  always_comb begin
    cur_cnt_s = '0;
    for (int b = 0; b < BANK_COUNT; b++) begin
      if (bus.wr_bank == BW'(b)) cur_cnt_s = cnt_r[b];
      else                       cur_cnt_s = cur_cnt_s;
    end
  end

  // Classify an accepted word as written, dropped on overflow, or discarded.
  always_comb begin
    accept_s  = bus.wr_valid && wr_ready_r;
    bank_ok_s = ({1'b0, bus.wr_bank} < BANK_LIM);
`ifdef DOUBLE_BUFFER_FRAME_DROP_EN
    drop_mode_s = (state_r == ST_PENDING);
`else
    drop_mode_s = 1'b0;
`endif
    write_s   = 1'b0;
    ovf_hit_s = 1'b0;
    if (accept_s && bank_ok_s && !drop_mode_s) begin
      if (cur_cnt_s == FRAME_LIM) ovf_hit_s = 1'b1;
      else                        write_s   = 1'b1;
    end else begin
      write_s   = 1'b0;
      ovf_hit_s = 1'b0;
    end
  end

  // Registered write port, buffer selects, frame status and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ce_r       <= 2'b00;
      wr_bank_q_r   <= '0;
      wr_addr_r     <= '0;
      wr_sel_r      <= 1'b0;
      rd_sel_r      <= 1'b1;
      frame_valid_r <= 1'b0;
      swap_pulse_r  <= 1'b0;
      overflow_r    <= 1'b0;
    end else begin
      swap_pulse_r <= (state_r == ST_SWAP);
      if (write_s) begin
        wr_ce_r     <= wr_sel_r ? 2'b10 : 2'b01;
        wr_bank_q_r <= bus.wr_bank;
        wr_addr_r   <= cur_cnt_s[AW-1:0];
      end else begin
        wr_ce_r <= 2'b00;
      end
      if (ovf_hit_s) overflow_r <= 1'b1;
      if (state_r == ST_SWAP) begin
        wr_sel_r      <= ~wr_sel_r;
        rd_sel_r      <= wr_sel_r;
        frame_valid_r <= 1'b1;
      end
    end
  end

  // Per-bank word counters; cleared on every swap (no accept can occur then).
  always_ff @(posedge clk) begin
    for (int b = 0; b < BANK_COUNT; b++) begin
      if (reset || (state_r == ST_SWAP)) begin
        cnt_r[b] <= '0;
      end else if (write_s && (bus.wr_bank == BW'(b))) begin
        cnt_r[b] <= cnt_r[b] + CNT_ONE;
      end else begin
        cnt_r[b] <= cnt_r[b];
      end
    end
  end

`ifdef DOUBLE_BUFFER_FRAME_DROP_EN
  logic [15:0] drop_count_r;
  assign drop_count = drop_count_r;

  // Saturating count of frames the writer ended while the reader was busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count_r <= 16'd0;
    end else if ((state_r == ST_PENDING) && bus.wr_frame_end &&
                 (drop_count_r != 16'hFFFF)) begin
      drop_count_r <= drop_count_r + 16'd1;
    end else begin
      drop_count_r <= drop_count_r;
    end
  end
`endif
endmodule

// File: tb/tb_double_buffer_swap_ctrl.sv
// Self-checking bench for double_buffer_swap_ctrl: directed scenarios with
// literal expectations, then randomized traffic checked every cycle against
// a behavioural model of the frame/swap rules.
module tb_double_buffer_swap_ctrl;
  localparam int AD = 8;
  localparam int BC = 3;
  localparam int FW = 4;
`ifdef DOUBLE_BUFFER_FRAME_DROP_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  double_buffer_swap_ctrl_if #(.ADDRESS_DEPTH(AD), .BANK_COUNT(BC)) bus ();
`ifdef DOUBLE_BUFFER_FRAME_DROP_EN
  logic [15:0] drop_count;
  double_buffer_swap_ctrl #(.ADDRESS_DEPTH(AD), .BANK_COUNT(BC), .FRAME_WORDS(FW))
    dut (.clk(clk), .reset(reset), .drop_count(drop_count), .bus(bus));
`else
  double_buffer_swap_ctrl #(.ADDRESS_DEPTH(AD), .BANK_COUNT(BC), .FRAME_WORDS(FW))
    dut (.clk(clk), .reset(reset), .bus(bus));
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 = no frame yet, 1 = filling, 2 = writer done, waiting for reader
  int       m_phase;
  bit       m_in_swap, m_ready, m_wr_sel, m_rd_sel, m_fv, m_pulse, m_ovf;
  int       m_cnt [BC];
  logic [1:0] e_ce;
  int       e_addr, e_bank, m_drop, m_bank;
  bit       m_acc;

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0; m_in_swap = 0; m_ready = 1; m_wr_sel = 0; m_rd_sel = 1;
      m_fv = 0; m_pulse = 0; m_ovf = 0; e_ce = 2'b00; m_drop = 0;
      e_addr = 0; e_bank = 0;
      for (int b = 0; b < BC; b++) m_cnt[b] = 0;
    end else begin
      m_acc  = bus.wr_valid && m_ready;
      m_bank = int'(bus.wr_bank);
      e_ce   = 2'b00;
      m_pulse = 0;
      if (m_in_swap) begin
        m_wr_sel = !m_wr_sel;
        m_rd_sel = !m_wr_sel;
        for (int b = 0; b < BC; b++) m_cnt[b] = 0;
        m_fv = 1; m_pulse = 1; m_in_swap = 0; m_phase = 1;
      end else begin
        if (m_acc && m_bank < BC && !(DROP_EN && m_phase == 2)) begin
          if (m_cnt[m_bank] >= FW) m_ovf = 1;
          else begin
            e_ce = m_wr_sel ? 2'b10 : 2'b01;
            e_addr = m_cnt[m_bank];
            e_bank = m_bank;
            m_cnt[m_bank]++;
          end
        end
        if (DROP_EN && m_phase == 2 && bus.wr_frame_end && m_drop < 65535) m_drop++;
        if (m_phase == 0 && bus.wr_frame_end) m_in_swap = 1;
        else if (m_phase == 1 && bus.wr_frame_end && bus.rd_frame_done) m_in_swap = 1;
        else if (m_phase == 1 && bus.wr_frame_end) m_phase = 2;
        else if (m_phase == 2 && bus.rd_frame_done) m_in_swap = 1;
      end
      m_ready = !m_in_swap && (m_phase != 2 || DROP_EN);
    end
  end

  // Per-cycle compare of every DUT output against the model.
  always @(negedge clk) begin
    vectors++;
    chk("wr_ready", 32'(bus.wr_ready), 32'(m_ready));
    chk("wr_ce", 32'(bus.wr_ce), 32'(e_ce));
    if (e_ce != 2'b00) begin
      chk("wr_addr", 32'(bus.wr_addr), 32'(e_addr));
      chk("wr_bank_q", 32'(bus.wr_bank_q), 32'(e_bank));
    end
    chk("rd_sel", 32'(bus.rd_sel), 32'(m_rd_sel));
    chk("frame_valid", 32'(bus.frame_valid), 32'(m_fv));
    chk("swap_pulse", 32'(bus.swap_pulse), 32'(m_pulse));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    if (bus.frame_valid === 1'b1)
      chk("ce_vs_rd_sel", 32'(bus.wr_ce[bus.rd_sel]), 32'd0);
`ifdef DOUBLE_BUFFER_FRAME_DROP_EN
    chk("drop_count", 32'(drop_count), 32'(m_drop));
`endif
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic v, input logic [1:0] bank, input logic fe, input logic rd);
    bus.wr_valid = v; bus.wr_bank = bank; bus.wr_frame_end = fe; bus.rd_frame_done = rd;
    @(negedge clk);
  endtask

  initial begin
    bus.wr_valid = 1'b0; bus.wr_bank = 2'd0; bus.wr_frame_end = 1'b0; bus.rd_frame_done = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
    chk("rst_rd_sel", 32'(bus.rd_sel), 32'd1);
    chk("rst_frame_valid", 32'(bus.frame_valid), 32'd0);
    chk("rst_wr_ce", 32'(bus.wr_ce), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);

    // Fill: 4 words to bank 0, 2 to bank 2, buffer 0.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 2'd0, 1'b0, 1'b0);
      chk("fill_b0_ce", 32'(bus.wr_ce), 32'd1);
      chk("fill_b0_addr", 32'(bus.wr_addr), 32'(i));
      chk("fill_b0_bank", 32'(bus.wr_bank_q), 32'd0);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 2'd2, 1'b0, 1'b0);
      chk("fill_b2_ce", 32'(bus.wr_ce), 32'd1);
      chk("fill_b2_addr", 32'(bus.wr_addr), 32'(i));
      chk("fill_b2_bank", 32'(bus.wr_bank_q), 32'd2);
    end

    // Frame end in IDLE swaps without waiting for the reader.
    step(1'b0, 2'd0, 1'b1, 1'b0);
    chk("idle_swap_ready", 32'(bus.wr_ready), 32'd0);
    step(1'b0, 2'd0, 1'b0, 1'b0);
    chk("swap1_pulse", 32'(bus.swap_pulse), 32'd1);
    chk("swap1_rd_sel", 32'(bus.rd_sel), 32'd0);
    chk("swap1_fv", 32'(bus.frame_valid), 32'd1);
    step(1'b1, 2'd1, 1'b0, 1'b0);
    chk("buf1_ce", 32'(bus.wr_ce), 32'd2);
    chk("buf1_addr", 32'(bus.wr_addr), 32'd0);
    chk("buf1_pulse_gone", 32'(bus.swap_pulse), 32'd0);

    // Writer done, reader busy: stall (or discard) until rd_frame_done.
    step(1'b0, 2'd0, 1'b1, 1'b0);
    chk("pend_ready", 32'(bus.wr_ready), 32'(DROP_EN));
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'd0, 1'b0, 1'b0);
      chk("pend_ce", 32'(bus.wr_ce), 32'd0);
      chk("pend_ready_hold", 32'(bus.wr_ready), 32'(DROP_EN));
    end
    step(1'b1, 2'd0, 1'b0, 1'b1);
    chk("pend_swap_ready", 32'(bus.wr_ready), 32'd0);
    step(1'b1, 2'd0, 1'b0, 1'b0);
    chk("swap2_pulse", 32'(bus.swap_pulse), 32'd1);
    chk("swap2_rd_sel", 32'(bus.rd_sel), 32'd1);
    chk("swap2_ce", 32'(bus.wr_ce), 32'd0);
    step(1'b1, 2'd0, 1'b0, 1'b0);
    chk("held_word_ce", 32'(bus.wr_ce), 32'd1);
    chk("held_word_addr", 32'(bus.wr_addr), 32'd0);

    // Simultaneous frame end + reader done: direct swap, word to old buffer.
    step(1'b1, 2'd2, 1'b1, 1'b1);
    chk("sim_ce", 32'(bus.wr_ce), 32'd1);
    chk("sim_addr", 32'(bus.wr_addr), 32'd0);
    chk("sim_bank", 32'(bus.wr_bank_q), 32'd2);
    chk("sim_ready", 32'(bus.wr_ready), 32'd0);
    step(1'b0, 2'd0, 1'b0, 1'b0);
    chk("swap3_pulse", 32'(bus.swap_pulse), 32'd1);
    chk("swap3_rd_sel", 32'(bus.rd_sel), 32'd0);

    // Overflow: 5 words to bank 1 with a 4-word frame.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 2'd1, 1'b0, 1'b0);
      chk("ovf_ce", 32'(bus.wr_ce), 32'd2);
      chk("ovf_addr", 32'(bus.wr_addr), 32'(i));
    end
    step(1'b1, 2'd1, 1'b0, 1'b0);
    chk("ovf_drop_ce", 32'(bus.wr_ce), 32'd0);
    chk("ovf_flag", 32'(bus.overflow), 32'd1);
    step(1'b1, 2'd3, 1'b0, 1'b0);
    chk("bad_bank_ce", 32'(bus.wr_ce), 32'd0);
    step(1'b0, 2'd0, 1'b1, 1'b1);
    step(1'b0, 2'd0, 1'b0, 1'b0);
    chk("ovf_swap_pulse", 32'(bus.swap_pulse), 32'd1);
    chk("ovf_sticky", 32'(bus.overflow), 32'd1);

`ifdef DOUBLE_BUFFER_FRAME_DROP_EN
    // Drop mode: frames ended while waiting are counted, writer never stalls.
    step(1'b0, 2'd0, 1'b1, 1'b0);
    step(1'b1, 2'd0, 1'b0, 1'b0);
    chk("drop_ready", 32'(bus.wr_ready), 32'd1);
    step(1'b1, 2'd1, 1'b1, 1'b0);
    chk("drop_ce", 32'(bus.wr_ce), 32'd0);
    step(1'b1, 2'd2, 1'b0, 1'b0);
    step(1'b0, 2'd0, 1'b1, 1'b0);
    chk("drop_count2", 32'(drop_count), 32'd2);
    step(1'b0, 2'd0, 1'b0, 1'b1);
    step(1'b0, 2'd0, 1'b0, 1'b0);
    chk("drop_swap_pulse", 32'(bus.swap_pulse), 32'd1);
    step(1'b0, 2'd0, 1'b0, 1'b0);
    chk("drop_single_swap", 32'(bus.swap_pulse), 32'd0);
`endif

    // Randomized traffic with one mid-run reset.
    for (int i = 0; i < 3000; i++) begin
      reset = (i == 1500);
      step(1'(($urandom % 4) != 0), 2'($urandom % 4),
           1'(($urandom % 12) == 0), 1'(($urandom % 6) == 0));
    end
    reset = 1'b0;
    step(1'b0, 2'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
